// File: rtl/disp_req_arbiter.sv
// Two-requester digit-write arbiter for a 3-digit display with post-write grant lockout.
// Optional idle auto-blank enabled by defining DISP_REQ_ARBITER_AUTOBLANK_EN.
module disp_req_arbiter #(
    parameter int HOLD_CYC = 4,
    parameter int IDLE_TO  = 1000000
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       kp_req,
    input  logic [3:0] kp_val,
    output logic       kp_gnt,
    input  logic       pb_req,
    input  logic [3:0] pb_val,
    output logic       pb_gnt,
    input  logic       rec_mode,
    input  logic       disp_clr,
    output logic [3:0] DispVal,
    output logic [3:0] DispVal2,
    output logic [3:0] DispVal3,
    output logic       isRecord,
    output logic       busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_kp_q, last_kp_d;
    logic       isrec_q, isrec_d;
    logic       kp_gnt_q, kp_gnt_d;
    logic       pb_gnt_q, pb_gnt_d;
    logic [3:0] dig0_q, dig0_d;
    logic [3:0] dig1_q, dig1_d;
    logic [3:0] dig2_q, dig2_d;

    logic       kp_elig, pb_elig, win_kp, grant;
    logic [3:0] win_val;

`ifdef DISP_REQ_ARBITER_AUTOBLANK_EN
    localparam int IW = $clog2(IDLE_TO + 1);
    logic [IW-1:0] idle_q, idle_d;
`endif

    // Playback is only eligible when the registered mode says playback
    assign kp_elig = kp_req;
    assign pb_elig = pb_req & ~isrec_q;
    assign win_kp  = kp_elig & (~pb_elig | ~last_kp_q);
    assign win_val = win_kp ? kp_val : pb_val;
    assign grant   = (state_q == IDLE) & (kp_elig | pb_elig);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_kp_d = last_kp_q;
        isrec_d   = isrec_q;
        kp_gnt_d  = 1'b0;
        pb_gnt_d  = 1'b0;
        dig0_d    = dig0_q;
        dig1_d    = dig1_q;
        dig2_d    = dig2_q;
`ifdef DISP_REQ_ARBITER_AUTOBLANK_EN
        idle_d    = '0;
`endif
        if (state_q == IDLE) isrec_d = rec_mode;

        if (disp_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            dig0_d  = '0;
            dig1_d  = '0;
            dig2_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_d   = HOLD;
                        cnt_d     = 8'(HOLD_CYC - 1);
                        kp_gnt_d  = win_kp;
                        pb_gnt_d  = ~win_kp;
                        last_kp_d = win_kp;
                        // Codes 10..15 are acknowledged but never displayed
                        if (win_val < 4'd10) begin
                            dig2_d = dig1_q;
                            dig1_d = dig0_q;
                            dig0_d = win_val;
                        end
                    end else begin
`ifdef DISP_REQ_ARBITER_AUTOBLANK_EN
                        if (idle_q == IW'(IDLE_TO - 1)) begin
                            dig0_d = 4'hF;
                            dig1_d = 4'hF;
                            dig2_d = 4'hF;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_kp_q <= 1'b0;
            isrec_q   <= 1'b0;
            kp_gnt_q  <= 1'b0;
            pb_gnt_q  <= 1'b0;
            dig0_q    <= '0;
            dig1_q    <= '0;
            dig2_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_kp_q <= last_kp_d;
            isrec_q   <= isrec_d;
            kp_gnt_q  <= kp_gnt_d;
            pb_gnt_q  <= pb_gnt_d;
            dig0_q    <= dig0_d;
            dig1_q    <= dig1_d;
            dig2_q    <= dig2_d;
        end
    end

`ifdef DISP_REQ_ARBITER_AUTOBLANK_EN
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`endif

    assign kp_gnt   = kp_gnt_q;
    assign pb_gnt   = pb_gnt_q;
    assign DispVal  = dig0_q;
    assign DispVal2 = dig1_q;
    assign DispVal3 = dig2_q;
    assign isRecord = isrec_q;
    assign busy     = (state_q == HOLD);

endmodule

// File: tb/tb_disp_req_arbiter.sv
// Bench for disp_req_arbiter: per-cycle behavioural model plus directed scenarios.
module tb_disp_req_arbiter;
    localparam int HC  = 4;
    localparam int ITO = 20;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kp_req = 1'b0, pb_req = 1'b0, rec_mode = 1'b0, disp_clr = 1'b0;
    logic [3:0] kp_val = '0, pb_val = '0;
    logic       kp_gnt, pb_gnt, isRecord, busy;
    logic [3:0] DispVal, DispVal2, DispVal3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    disp_req_arbiter #(.HOLD_CYC(HC), .IDLE_TO(ITO)) dut (
        .fclk(fclk), .rst_n(rst_n),
        .kp_req(kp_req), .kp_val(kp_val), .kp_gnt(kp_gnt),
        .pb_req(pb_req), .pb_val(pb_val), .pb_gnt(pb_gnt),
        .rec_mode(rec_mode), .disp_clr(disp_clr),
        .DispVal(DispVal), .DispVal2(DispVal2), .DispVal3(DispVal3),
        .isRecord(isRecord), .busy(busy)
    );

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: digits as a newest-first list, hold as remaining lockout cycles (0 = idle)
    typedef struct {
        int d0, d1, d2;
        int hold;
        bit last_kp;
        bit isrec;
        bit kpg, pbg;
        int idle;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(mstate_t s);
        mstate_t n;
        bit ke, pe, wk;
        int v;
        n = s;
        n.kpg = 0;
        n.pbg = 0;
        if (s.hold == 0) n.isrec = rec_mode;
        if (disp_clr) begin
            n.d0 = 0; n.d1 = 0; n.d2 = 0;
            n.hold = 0;
            n.idle = 0;
        end else if (s.hold > 0) begin
            n.hold = s.hold - 1;
            n.idle = 0;
        end else begin
            ke = kp_req;
            pe = pb_req && !s.isrec;
            if (ke || pe) begin
                wk = ke && (!pe || !s.last_kp);
                v = wk ? int'(kp_val) : int'(pb_val);
                n.kpg = wk;
                n.pbg = !wk;
                n.last_kp = wk;
                n.hold = HC;
                n.idle = 0;
                if (v <= 9) begin
                    n.d2 = s.d1; n.d1 = s.d0; n.d0 = v;
                end
            end else begin
                n.idle = s.idle + 1;
`ifdef DISP_REQ_ARBITER_AUTOBLANK_EN
                if (n.idle == ITO) begin
                    n.d0 = 15; n.d1 = 15; n.d2 = 15;
                    n.idle = 0;
                end
`endif
            end
        end
        return n;
    endfunction

    always @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{d0: 0, d1: 0, d2: 0, hold: 0, last_kp: 0, isrec: 0, kpg: 0, pbg: 0, idle: 0};
        end else begin
            m <= step(m);
        end
    end

    always @(negedge fclk) begin
        chk("m_DispVal",  DispVal,  m.d0);
        chk("m_DispVal2", DispVal2, m.d1);
        chk("m_DispVal3", DispVal3, m.d2);
        chk("m_kp_gnt",   kp_gnt,   m.kpg);
        chk("m_pb_gnt",   pb_gnt,   m.pbg);
        chk("m_isRecord", isRecord, m.isrec);
        chk("m_busy",     busy,     m.hold > 0);
        chk("one_gnt",    kp_gnt & pb_gnt, 1'b0);
    end

    task automatic do_reset(input logic rm);
        @(negedge fclk);
        #2;
        rst_n = 1'b0;
        kp_req = 0; pb_req = 0; disp_clr = 0; rec_mode = rm;
        kp_val = 0; pb_val = 0;
        @(negedge fclk);
        chk("rst_DispVal", DispVal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {kp_gnt, pb_gnt}, 0);
        chk("rst_isRecord", isRecord, 0);
        #2;
        rst_n = 1'b1;
    endtask

    // Returns at the negedge where the requested grant is visible
    task automatic wait_gnt(input bit kp, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge fclk);
            if (kp ? kp_gnt : pb_gnt) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(kp ? "timeout_kp_gnt" : "timeout_pb_gnt", 0, 1);
    endtask

    task automatic wait_any(output int who);
        who = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge fclk);
            if (kp_gnt) begin who = 0; break; end
            if (pb_gnt) begin who = 1; break; end
        end
        if (who < 0) chk("timeout_any_gnt", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) return;
            @(negedge fclk);
        end
        chk("timeout_idle", busy, 0);
    endtask

    int t[4];
    int who, bcount, seen;

    initial begin
        // Single keypad write after reset
        do_reset(0);
        @(negedge fclk);
        kp_req = 1; kp_val = 5;
        @(negedge fclk);
        chk("w5_kp_gnt", kp_gnt, 1);
        chk("w5_DispVal", DispVal, 5);
        chk("w5_DispVal2", DispVal2, 0);
        chk("w5_DispVal3", DispVal3, 0);
        kp_req = 0;
        bcount = busy ? 1 : 0;
        repeat (6) begin
            @(negedge fclk);
            if (busy) bcount++;
        end
        chk("w5_busy_cycles", bcount, HC);

        // Continuous keypad writes 1,2,3,4 and grant spacing
        do_reset(0);
        kp_req = 1; kp_val = 1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(1, t[i]);
            kp_val = 4'(i + 2);
        end
        kp_req = 0;
        chk("seq_DispVal", DispVal, 4);
        chk("seq_DispVal2", DispVal2, 3);
        chk("seq_DispVal3", DispVal3, 2);
        for (int i = 1; i < 4; i++) chk("seq_spacing", t[i] - t[i-1], HC + 1);

        // Round-robin under a permanent tie
        do_reset(0);
        kp_req = 1; pb_req = 1; kp_val = 7; pb_val = 8;
        for (int i = 0; i < 4; i++) begin
            wait_any(who);
            chk("rr_order", who, i % 2);
        end
        kp_req = 0; pb_req = 0;
        chk("rr_DispVal", DispVal, 8);
        chk("rr_DispVal2", DispVal2, 7);

        // Record mode blocks playback; mode change during hold
        do_reset(1);
        repeat (2) @(negedge fclk);
        chk("rec_isRecord", isRecord, 1);
        pb_req = 1; pb_val = 6;
        seen = 0;
        repeat (10) begin
            @(negedge fclk);
            if (pb_gnt) seen++;
        end
        chk("rec_pb_blocked", seen, 0);
        kp_req = 1; kp_val = 3;
        wait_gnt(1, t[0]);
        kp_req = 0;
        rec_mode = 0;
        chk("rec_busy", busy, 1);
        chk("rec_isRecord_hold", isRecord, 1);
        wait_gnt(0, t[1]);
        pb_req = 0;
        chk("rec_isRecord_after", isRecord, 0);
        chk("rec_DispVal", DispVal, 6);
        chk("rec_DispVal2", DispVal2, 3);
        chk("rec_pb_latency", t[1] - t[0], HC + 2);

        // Non-digit code and clear
        do_reset(0);
        kp_req = 1; kp_val = 5;
        wait_gnt(1, t[0]);
        kp_req = 0;
        wait_idle();
        kp_req = 1; kp_val = 12;
        wait_gnt(1, t[1]);
        kp_req = 0;
        chk("c12_DispVal", DispVal, 5);
        chk("c12_DispVal2", DispVal2, 0);
        chk("c12_busy", busy, 1);
        wait_idle();
        kp_req = 1; kp_val = 9; disp_clr = 1;
        @(negedge fclk);
        chk("clr_DispVal", DispVal, 0);
        chk("clr_kp_gnt", kp_gnt, 0);
        chk("clr_busy", busy, 0);
        disp_clr = 0;
        @(negedge fclk);
        chk("clr_next_kp_gnt", kp_gnt, 1);
        chk("clr_next_DispVal", DispVal, 9);
        kp_req = 0;
        @(negedge fclk);
        disp_clr = 1;
        @(negedge fclk);
        chk("clr_abort_busy", busy, 0);
        disp_clr = 0;

        // Asynchronous reset in the middle of a hold
        do_reset(0);
        kp_req = 1; kp_val = 7;
        wait_gnt(1, t[0]);
        kp_req = 0;
        @(negedge fclk);
        chk("mid_busy_before", busy, 1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_DispVal", DispVal, 0);
        @(negedge fclk);
        #2;
        rst_n = 1;

        // Long idle after three writes
        do_reset(0);
        kp_req = 1; kp_val = 1;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(1, t[i]);
            kp_val = 4'(i + 2);
        end
        kp_req = 0;
        wait_idle();
        repeat (25) @(negedge fclk);
`ifdef DISP_REQ_ARBITER_AUTOBLANK_EN
        chk("idle_DispVal", DispVal, 15);
        chk("idle_DispVal2", DispVal2, 15);
        chk("idle_DispVal3", DispVal3, 15);
`else
        chk("idle_DispVal", DispVal, 3);
        chk("idle_DispVal2", DispVal2, 2);
        chk("idle_DispVal3", DispVal3, 1);
`endif

        @(negedge fclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
